// File: rtl/pipe_sub2_slice.sv
// pipe_sub2_slice: pipelined a - b - borrow_in, two bits per stage, borrow ripples stage to stage.
module pipe_sub2_slice #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             zero
);
   localparam int STAGES = WIDTH / 2;

   // x holds unconsumed minuend bits low and resolved diff bits high; after the last stage it is the full diff
   logic [STAGES-1:0] v_q, v_d, bw_q, bw_d, sa_q, sa_d, sb_q, sb_d;
   logic [STAGES-1:0] sv, sbw, ssa, ssb;
   logic [WIDTH-1:0]  x_q [STAGES];
   logic [WIDTH-1:0]  x_d [STAGES];
   logic [WIDTH-1:0]  y_q [STAGES-1];
   logic [WIDTH-1:0]  y_d [STAGES-1];
   logic [WIDTH-1:0]  sx  [STAGES];
   logic [WIDTH-1:0]  sy  [STAGES];
   logic              adv;
   logic [2:0]        r;

   function automatic logic [2:0] sub2(input logic [1:0] x, input logic [1:0] y, input logic bw);
      logic [2:0] o;
      o[2] = bw;
      for (int i = 0; i < 2; i++) begin
         o[i] = x[i] ^ y[i] ^ o[2];
         o[2] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & o[2]);
      end
      return o;
   endfunction

   always_comb begin
      adv = out_ready || !v_q[STAGES-1];
      r = '0;
      sv  = {v_q[STAGES-2:0], in_valid};
      sbw = {bw_q[STAGES-2:0], borrow_in};
      ssa = {sa_q[STAGES-2:0], a[WIDTH-1]};
      ssb = {sb_q[STAGES-2:0], b[WIDTH-1]};
      sx[0] = a;
      sy[0] = b;
      for (int k = 1; k < STAGES; k++) begin
         sx[k] = x_q[k-1];
         sy[k] = y_q[k-1];
      end
      v_d  = adv ? sv : v_q;
      sa_d = adv ? ssa : sa_q;
      sb_d = adv ? ssb : sb_q;
      bw_d = bw_q;
      for (int k = 0; k < STAGES; k++) begin
         r = sub2(sx[k][1:0], sy[k][1:0], sbw[k]);
         x_d[k] = adv ? {r[1:0], sx[k][WIDTH-1:2]} : x_q[k];
         bw_d[k] = adv ? r[2] : bw_q[k];
      end
      for (int k = 0; k < STAGES - 1; k++)
         y_d[k] = adv ? {2'b00, sy[k][WIDTH-1:2]} : y_q[k];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q  <= '0;
         bw_q <= '0;
         sa_q <= '0;
         sb_q <= '0;
         x_q  <= '{default: '0};
         y_q  <= '{default: '0};
      end else begin
         v_q  <= v_d;
         bw_q <= bw_d;
         sa_q <= sa_d;
         sb_q <= sb_d;
         x_q  <= x_d;
         y_q  <= y_d;
      end
   end

   assign in_ready   = adv;
   assign out_valid  = v_q[STAGES-1];
   assign diff       = x_q[STAGES-1];
   assign borrow_out = bw_q[STAGES-1];
   assign zero       = v_q[STAGES-1] && (x_q[STAGES-1] == '0);
   assign overflow   = (sa_q[STAGES-1] != sb_q[STAGES-1]) && (x_q[STAGES-1][WIDTH-1] != sa_q[STAGES-1]);
endmodule

// File: tb/tb_pipe_sub2_slice.sv
// tb_pipe_sub2_slice: directed and streamed checks of the pipelined subtractor.
module tb_pipe_sub2_slice;
   localparam int W = 32;
   localparam int LAT = 16;

   typedef struct packed {
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
      logic         z;
   } exp_t;

   logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, borrow_in = 1'b0, out_ready = 1'b1;
   logic         in_ready, out_valid, borrow_out, overflow, zero;
   logic [W-1:0] a = '0, b = '0, diff;
   int           errors = 0, checks = 0;
   exp_t         exp_q[$];

   always #5 clk = ~clk;

   pipe_sub2_slice #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .borrow_in(borrow_in), .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
      .borrow_out(borrow_out), .overflow(overflow), .zero(zero)
   );

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
      logic [W:0] r;
      exp_t e;
      r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
      e.d  = r[W-1:0];
      e.bo = r[W];
      e.ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      e.z  = (r[W-1:0] == '0);
      return e;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      checks++; if (diff !== '0) begin errors++; $display("FAIL reset_diff: got %h want 0", diff); end
      checks++; if ({borrow_out, overflow, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {borrow_out, overflow, zero}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      rst = 1'b0;
   endtask

   task automatic run_one(input string name, input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          input logic [W-1:0] ed, input logic ebo, input logic eov, input logic ez);
      int lat;
      lat = 0;
      @(negedge clk);
      a = av; b = bv; borrow_in = bi; in_valid = 1'b1; out_ready = 1'b1;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 40);
      checks++; if (lat != LAT) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT); end
      checks++; if (diff !== ed) begin errors++; $display("FAIL %s_diff: got %h want %h", name, diff, ed); end
      checks++; if (borrow_out !== ebo) begin errors++; $display("FAIL %s_borrow: got %0b want %0b", name, borrow_out, ebo); end
      checks++; if (overflow !== eov) begin errors++; $display("FAIL %s_overflow: got %0b want %0b", name, overflow, eov); end
      checks++; if (zero !== ez) begin errors++; $display("FAIL %s_zero: got %0b want %0b", name, zero, ez); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_single_beat: got %0b want 0", name, out_valid); end
   endtask

   task automatic test_basic();
      run_one("sub_5_3", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_boundaries();
      run_one("zero_minus_one", 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      run_one("equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_overflow();
      run_one("min_minus_one", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      run_one("one_minus_two", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      run_one("max_minus_neg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      int it, got, sent, first, last;
      exp_t e;
      it = 0; got = 0; sent = 0; first = -1; last = -1;
      exp_q.delete();
      out_ready = 1'b1;
      while (got < 40 && it < 200) begin
         @(negedge clk);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++; $display("FAIL b2b_extra_result: got %h want none", diff);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if ({diff, borrow_out, overflow, zero} !== e) begin
                  errors++; $display("FAIL b2b_result_%0d: got %h/%b want %h/%b", got, diff, {borrow_out, overflow, zero}, e.d, {e.bo, e.ov, e.z});
               end
            end
            if (first < 0) first = it;
            last = it;
            got++;
         end
         if (sent < 40) begin
            a = $urandom; b = $urandom; borrow_in = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            exp_q.push_back(model(a, b, borrow_in));
            sent++;
         end else in_valid = 1'b0;
         it++;
      end
      in_valid = 1'b0;
      checks++; if (got != 40) begin errors++; $display("FAIL b2b_count: got %0d want 40", got); end
      checks++; if (first != LAT) begin errors++; $display("FAIL b2b_first_cycle: got %0d want %0d", first, LAT); end
      checks++; if (last != first + 39) begin errors++; $display("FAIL b2b_consecutive: got last %0d want %0d", last, first + 39); end
   endtask

   task automatic test_stall();
      int it, got, sent;
      logic hold, pend;
      exp_t held, e;
      it = 0; got = 0; sent = 0; hold = 1'b0; pend = 1'b0; held = '0;
      exp_q.delete();
      while (got < 60 && it < 3000) begin
         @(negedge clk);
         if (hold) begin
            checks++;
            if (!out_valid || {diff, borrow_out, overflow, zero} !== held) begin
               errors++; $display("FAIL stall_stable: got v=%0b %h want v=1 %h", out_valid, diff, held.d);
            end
         end
         out_ready = 1'($urandom_range(0, 1));
         if (sent < 60 && !pend && $urandom_range(0, 3) != 0) begin
            a = $urandom; b = $urandom; borrow_in = 1'($urandom_range(0, 1)); pend = 1'b1;
         end
         in_valid = pend;
         #1;
         checks++;
         if (in_ready !== (out_ready || !out_valid)) begin
            errors++; $display("FAIL stall_in_ready: got %0b want %0b", in_ready, out_ready || !out_valid);
         end
         hold = out_valid && !out_ready;
         held = {diff, borrow_out, overflow, zero};
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++; $display("FAIL stall_extra_result: got %h want none", diff);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if ({diff, borrow_out, overflow, zero} !== e) begin
                  errors++; $display("FAIL stall_result_%0d: got %h/%b want %h/%b", got, diff, {borrow_out, overflow, zero}, e.d, {e.bo, e.ov, e.z});
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, borrow_in));
            sent++;
            pend = 1'b0;
         end
         it++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++; if (got != 60) begin errors++; $display("FAIL stall_count: got %0d want 60", got); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_leftover: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a = $urandom; b = $urandom; borrow_in = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
      checks++; if (diff !== '0) begin errors++; $display("FAIL midrst_diff: got %h want 0", diff); end
      checks++; if ({borrow_out, overflow, zero} !== 3'b000) begin errors++; $display("FAIL midrst_flags: got %b want 000", {borrow_out, overflow, zero}); end
      run_one("after_reset", 32'h0000_0010, 32'h0000_0001, 1'b1, 32'h0000_000E, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_overflow();
      test_back_to_back();
      test_stall();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_sub2_slice.md
Name: pipe_sub2_slice

Overview:
- Pipelined subtractor: A − B − borrow_in, resolved 2 bits per stage with the borrow rippling from stage to stage.
- It is the inverse counterpart of the 2-bit full-adder slice chain used in the carry-select adder path.
- It sits in the execute path as the SUB/SLT/compare engine.
- It accepts one operand pair per cycle behind a valid/ready handshake, and returns difference plus flags after a fixed pipeline latency.

Parameters:
- WIDTH, 32, operand width in bits; must be even and ≥ 4.
- STAGES, WIDTH/2, derived (localparam, not overridable); number of 2-bit pipeline stages, equal to the latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  minuend (unsigned/two's-complement agnostic)
- b  input  WIDTH  subtrahend
- borrow_in  input  1  incoming borrow (1 = subtract one more)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- diff  output  WIDTH  (a − b − borrow_in) mod 2^WIDTH
- borrow_out  output  1  1 iff unsigned a < b + borrow_in
- overflow  output  1  signed overflow: a[W-1] != b[W-1] && diff[W-1] != a[W-1]
- zero  output  1  diff == 0

Behaviour:
- Single clock domain; all state updates on the rising edge of clk. Reset is synchronous and active-high.
- Reset:
  - Every stage valid bit clears to 0.
  - out_valid = 0, diff = 0, borrow_out = 0, overflow = 0, zero = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight operations; no partial result is ever presented.
- Handshake:
  - Transfer in: in_valid && in_ready at a clock edge.
  - Transfer out: out_valid && out_ready at a clock edge.
  - diff and flags hold stable while out_valid && !out_ready.
- Global-advance pipeline:
  - advance = out_ready || !out_valid.
  - in_ready = advance, combinational from out_ready and registered out_valid only.
  - When advance = 0, every stage holds, including its valid bit.
  - Bubbles are not collapsed. A bubble (valid 0) advances like data.
- Stage k (0..STAGES−1) computes bits [2k+1:2k]:
  - Per bit: d = x ^ y ^ bw; bw_next = (~x & y) | (~(x ^ y) & bw).
  - Stage 0 uses bw = borrow_in.
  - Stage k > 0 uses the registered borrow from stage k−1.
- Per-stage registers:
  - valid bit.
  - Partial diff bits [2k+1:0] already resolved.
  - Not-yet-consumed upper operand bits of a and b (skew registers).
  - Borrow.
  - Sign bits a[W−1] and b[W−1], carried for overflow.
- The last stage register drives the outputs directly. zero and overflow are computed from its contents; no extra cycle.
- Latency is exactly STAGES cycles from the input transfer edge to out_valid, absent stalls. Each stall cycle adds one cycle.
- Throughput: one operation per cycle when out_ready is held at 1.
- Ordering: results leave in acceptance order; no drop, no duplication.
- Boundaries:
  - a == b with borrow_in = 0 → diff = 0, zero = 1, borrow_out = 0.
  - 0 − 0 − 1 → all-ones, borrow_out = 1.
  - Wrap-around is mod 2^WIDTH; no saturation.
- Simultaneous events:
  - Input accept and output drain in the same cycle are both legal; this is the full-pipeline steady state.
  - in_valid while in_ready = 0: the operand is not captured, and the source must hold it.
- a, b and borrow_in are don't-care while in_valid = 0. A bubble's captured data is never presented (out_valid = 0).

Test Plan (WIDTH = 32, STAGES = 16):
- Reset, then a = 0x0000_0005, b = 0x0000_0003, borrow_in = 0, out_ready = 1 → after 16 cycles: out_valid = 1 for one cycle, diff = 0x0000_0002, borrow_out = 0, zero = 0, overflow = 0.
- a = 0, b = 0, borrow_in = 1 → diff = 0xFFFF_FFFF, borrow_out = 1. Then a = b = 0x1234_5678, borrow_in = 0 → diff = 0, zero = 1.
- a = 0x8000_0000, b = 0x0000_0001 → diff = 0x7FFF_FFFF, overflow = 1, borrow_out = 0. Then a = 0x0000_0001, b = 0x0000_0002 → diff = 0xFFFF_FFFF, borrow_out = 1, overflow = 0.
- Back-to-back stream of 40 random pairs with out_ready = 1 → 40 results in order on consecutive cycles, matching the scoreboard, first result at cycle 16.
- Stream with out_ready toggled pseudo-randomly (50 %) → in_ready == (out_ready || !out_valid) every cycle. Outputs stay stable during stalls; no loss or duplication against the scoreboard.
- Assert rst for one cycle with 10 operations in flight → next cycle out_valid = 0 and all outputs 0. A new operation accepted afterwards returns a correct result 16 cycles later; no stale result appears.
